// File: rtl/riscv_multicycle_if.sv
// Fetch, retire and debug-read signals of the multi-cycle RV32I core.
// The core uses the master modport; the source and retire monitor use slave.
interface riscv_multicycle_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [31:0] pc;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic [31:0] aluresult;
   logic        branch_taken;
   logic        illegal;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;

   modport master (
      input  instr_valid, instr, dbg_raddr,
      output instr_ready, pc, retire_valid, retire_pc, aluresult,
             branch_taken, illegal, dbg_rdata
   );

   modport slave (
      output instr_valid, instr, dbg_raddr,
      input  instr_ready, pc, retire_valid, retire_pc, aluresult,
             branch_taken, illegal, dbg_rdata
   );
endinterface

// File: rtl/riscv_multicycle.sv
// Multi-cycle RV32I integer core: OP, OP-IMM, LUI and branches, one
// instruction per four cycles, with an internal register file of NUM_REGS.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | one cycle after reset release, no fetch yet
// S_FETCH     | instr_ready high, waiting for the source handshake
// S_DECODE    | classify IR, latch rs1/rs2 values and immediate
// S_EXECUTE   | compute ALU result / branch condition into retire regs
// S_WRITEBACK | retire pulse; pc and rd update on the closing edge
module riscv_multicycle #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   riscv_multicycle_if.master bus
);

   localparam int         AW   = $clog2(NUM_REGS);
   localparam logic [5:0] NREG = 6'(NUM_REGS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK
   } state_t;

   typedef enum logic [2:0] {
      K_OP,
      K_OPIMM,
      K_LUI,
      K_BRANCH,
      K_ILLEGAL
   } kind_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;
   logic [31:0] ir;
   logic [31:0] rs1_val, rs2_val, imm;
   kind_t       kind;

   logic        retire_valid_q;
   logic [31:0] retire_pc_q;
   logic [31:0] aluresult_q;
   logic        taken_q;
   logic        illegal_q;

   logic [31:0] regs [NUM_REGS];

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        handshake;

   assign opcode    = ir[6:0];
   assign rd        = ir[11:7];
   assign funct3    = ir[14:12];
   assign rs1       = ir[19:15];
   assign rs2       = ir[24:20];
   assign funct7    = ir[31:25];
   assign handshake = bus.instr_valid && (state == S_FETCH);

   // ---------------- register reads (x0 and out-of-range read as 0) ----------
   logic [31:0] rs1_rd, rs2_rd;

   assign rs1_rd = (rs1 != 5'd0 && {1'b0, rs1} < NREG) ? regs[rs1[AW-1:0]] : 32'd0;
   assign rs2_rd = (rs2 != 5'd0 && {1'b0, rs2} < NREG) ? regs[rs2[AW-1:0]] : 32'd0;
   assign bus.dbg_rdata = (bus.dbg_raddr != 5'd0 && {1'b0, bus.dbg_raddr} < NREG)
                          ? regs[bus.dbg_raddr[AW-1:0]] : 32'd0;

   // ---------------- decode ----------------
   kind_t       kind_dec;
   logic [31:0] imm_dec;
   logic        uses_rd, uses_rs1, uses_rs2;

   always_comb begin
      kind_dec = K_ILLEGAL;
      imm_dec  = {{20{ir[31]}}, ir[31:20]};
      unique case (opcode)
         7'b0110011: begin
            if (funct7 == 7'h00 ||
                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
               kind_dec = K_OP;
         end
         7'b0010011: begin
            if (funct3 == 3'b001)
               kind_dec = (funct7 == 7'h00) ? K_OPIMM : K_ILLEGAL;
            else if (funct3 == 3'b101)
               kind_dec = (funct7 == 7'h00 || funct7 == 7'h20) ? K_OPIMM : K_ILLEGAL;
            else
               kind_dec = K_OPIMM;
         end
         7'b0110111: begin
            kind_dec = K_LUI;
            imm_dec  = {ir[31:12], 12'd0};
         end
         7'b1100011: begin
            if (funct3 != 3'b010 && funct3 != 3'b011)
               kind_dec = K_BRANCH;
            imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         end
         default: kind_dec = K_ILLEGAL;
      endcase

      // only the fields an instruction actually uses are range-checked
      uses_rd  = (kind_dec == K_OP) || (kind_dec == K_OPIMM) || (kind_dec == K_LUI);
      uses_rs1 = (kind_dec == K_OP) || (kind_dec == K_OPIMM) || (kind_dec == K_BRANCH);
      uses_rs2 = (kind_dec == K_OP) || (kind_dec == K_BRANCH);
      if ((uses_rd  && {1'b0, rd}  >= NREG) ||
          (uses_rs1 && {1'b0, rs1} >= NREG) ||
          (uses_rs2 && {1'b0, rs2} >= NREG))
         kind_dec = K_ILLEGAL;
   end

   // ---------------- execute ----------------
   logic [31:0] op_b, alu_out, diff, result;
   logic [4:0]  shamt;
   logic        cond, taken;

   assign op_b  = (kind == K_OPIMM) ? imm : rs2_val;
   assign shamt = op_b[4:0];
   assign diff  = rs1_val - rs2_val;

   always_comb begin
      alu_out = 32'd0;
      unique case (funct3)
         3'b000: alu_out = (kind == K_OP && funct7[5]) ? rs1_val - op_b : rs1_val + op_b;
         3'b001: alu_out = rs1_val << shamt;
         3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(op_b)};
         3'b011: alu_out = {31'd0, rs1_val < op_b};
         3'b100: alu_out = rs1_val ^ op_b;
         3'b101: alu_out = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
         3'b110: alu_out = rs1_val | op_b;
         3'b111: alu_out = rs1_val & op_b;
         default: alu_out = 32'd0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      unique case (funct3)
         3'b000: cond = (rs1_val == rs2_val);
         3'b001: cond = (rs1_val != rs2_val);
         3'b100: cond = $signed(rs1_val) <  $signed(rs2_val);
         3'b101: cond = $signed(rs1_val) >= $signed(rs2_val);
         3'b110: cond = rs1_val <  rs2_val;
         3'b111: cond = rs1_val >= rs2_val;
         default: cond = 1'b0;
      endcase
   end

   always_comb begin
      result = 32'd0;
      unique case (kind)
         K_OP, K_OPIMM: result = alu_out;
         K_LUI:         result = imm;
         K_BRANCH:      result = diff;
         default:       result = 32'd0;
      endcase
   end

   assign taken = (kind == K_BRANCH) && cond;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:      state_nxt = S_FETCH;
         S_FETCH:     if (handshake) state_nxt = S_DECODE;
         S_DECODE:    state_nxt = S_EXECUTE;
         S_EXECUTE:   state_nxt = S_WRITEBACK;
         S_WRITEBACK: state_nxt = S_FETCH;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_PC;
         ir             <= 32'd0;
         rs1_val        <= 32'd0;
         rs2_val        <= 32'd0;
         imm            <= 32'd0;
         kind           <= K_ILLEGAL;
         retire_valid_q <= 1'b0;
         retire_pc_q    <= 32'd0;
         aluresult_q    <= 32'd0;
         taken_q        <= 1'b0;
         illegal_q      <= 1'b0;
      end else begin
         retire_valid_q <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (handshake) ir <= bus.instr;
            end
            S_DECODE: begin
               rs1_val <= rs1_rd;
               rs2_val <= rs2_rd;
               imm     <= imm_dec;
               kind    <= kind_dec;
            end
            // retire fields are loaded here so they hold between pulses
            S_EXECUTE: begin
               retire_valid_q <= 1'b1;
               retire_pc_q    <= pc_q;
               aluresult_q    <= result;
               taken_q        <= taken;
               illegal_q      <= (kind == K_ILLEGAL);
            end
            S_WRITEBACK: begin
               pc_q <= taken_q ? pc_q + imm : pc_q + 32'd4;
            end
            default: ;
         endcase
      end
   end

   // ---------------- register file ----------------
   logic wr_en;

   assign wr_en = (state == S_WRITEBACK) && (rd != 5'd0) &&
                  (kind == K_OP || kind == K_OPIMM || kind == K_LUI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
      end else if (wr_en) begin
         regs[rd[AW-1:0]] <= aluresult_q;
      end
   end

   assign bus.instr_ready  = (state == S_FETCH);
   assign bus.pc           = pc_q;
   assign bus.retire_valid = retire_valid_q;
   assign bus.retire_pc    = retire_pc_q;
   assign bus.aluresult    = aluresult_q;
   assign bus.branch_taken = taken_q;
   assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Directed-program bench for riscv_multicycle (RV32E build, RESET_PC 0x100):
// driver queues expected retires, negedge monitor pops and compares.
module tb_riscv_multicycle;

   localparam logic [31:0] RPC = 32'h0000_0100;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] res;
      logic        taken;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic [31:0] res;
      logic        taken;
      logic        ill;
   } prog_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   riscv_multicycle_if bus ();

   riscv_multicycle #(.RESET_PC(RPC), .NUM_REGS(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    ncyc = 0;
   int    hs_cyc = 0;
   bit    hs_seen = 0;
   bit    chk_ready = 0;
   bit    toggle_en = 0;
   exp_t  sb[$];
   exp_t  mon_e;
   prog_t prog[$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         hs_seen   = 0;
         chk_ready = 0;
      end else begin
         if (chk_ready) begin
            check("ready_after_retire", {31'd0, bus.instr_ready}, 32'd1);
            chk_ready = 0;
         end
         if (bus.retire_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_retire: retire_pc %h with no expectation", bus.retire_pc);
            end else begin
               mon_e = sb.pop_front();
               check("retire_pc", bus.retire_pc, mon_e.pc);
               check($sformatf("aluresult@%h", mon_e.pc), bus.aluresult, mon_e.res);
               check($sformatf("branch_taken@%h", mon_e.pc), {31'd0, bus.branch_taken}, {31'd0, mon_e.taken});
               check($sformatf("illegal@%h", mon_e.pc), {31'd0, bus.illegal}, {31'd0, mon_e.ill});
               check("retire_latency", hs_seen ? ncyc - hs_cyc : -1, 32'd3);
            end
            chk_ready = 1;
            hs_seen   = 0;
         end
         if (bus.instr_valid && bus.instr_ready) begin
            hs_cyc  = ncyc;
            hs_seen = 1;
         end
      end
      ncyc++;
   end

   // ---------------- driver helpers ----------------
   task automatic issue(input logic [31:0] exp_pc, input logic [31:0] word,
                        input logic [31:0] res, input logic taken, input logic ill,
                        input bit push);
      int guard = 0;
      while (!bus.instr_ready && guard < 40) begin
         bus.instr_valid = toggle_en ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.instr       = $urandom;
         @(posedge clk); #1;
         guard++;
      end
      check("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
      if (toggle_en) begin
         repeat ($urandom_range(0, 1)) begin
            bus.instr_valid = 1'b0;
            @(posedge clk); #1;
         end
      end
      check("fetch_pc", bus.pc, exp_pc);
      bus.instr_valid = 1'b1;
      bus.instr       = word;
      if (push) sb.push_back(exp_t'{exp_pc, res, taken, ill});
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 100) begin
         @(posedge clk); #1;
         g++;
      end
      check("drain", sb.size(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic dbg_check(input int idx, input logic [31:0] exp);
      bus.dbg_raddr = 5'(idx);
      #1;
      check($sformatf("dbg_x%0d", idx), bus.dbg_rdata, exp);
   endtask

   function automatic void add(logic [31:0] pc, logic [31:0] word, logic [31:0] res,
                               logic taken, logic ill);
      prog.push_back(prog_t'{pc, word, res, taken, ill});
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      // x1=5, x2=-3 established first; later rows rely on them
      add(32'h0000_0104, 32'hFFD0_0113, 32'hFFFF_FFFD, 0, 0); // ADDI x2,x0,-3
      add(32'h0000_0108, 32'h0020_81B3, 32'h0000_0002, 0, 0); // ADD  x3,x1,x2
      add(32'h0000_010C, 32'h4011_0233, 32'hFFFF_FFF8, 0, 0); // SUB  x4,x2,x1
      add(32'h0000_0110, 32'h0011_22B3, 32'h0000_0001, 0, 0); // SLT  x5,x2,x1
      add(32'h0000_0114, 32'h0011_32B3, 32'h0000_0000, 0, 0); // SLTU x5,x2,x1
      add(32'h0000_0118, 32'h4011_5293, 32'hFFFF_FFFE, 0, 0); // SRAI x5,x2,1
      add(32'h0000_011C, 32'h0011_5313, 32'h7FFF_FFFE, 0, 0); // SRLI x6,x2,1
      add(32'h0000_0120, 32'hABCD_E337, 32'hABCD_E000, 0, 0); // LUI  x6,0xABCDE
      add(32'h0000_0124, 32'h0010_0A13, 32'h0000_0000, 0, 1); // ADDI x20,x0,1
      add(32'h0000_0128, 32'h0000_007F, 32'h0000_0000, 0, 1); // opcode 7F
      add(32'h0000_012C, 32'h0070_0013, 32'h0000_0007, 0, 0); // ADDI x0,x0,7
      add(32'h0000_0130, 32'h0010_9463, 32'h0000_0000, 0, 0); // BNE  x1,x1,+8
      add(32'h0000_0134, 32'hEC00_04E3, 32'h0000_0000, 1, 0); // BEQ  x0,x0,-312
      add(32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0000, 0, 0); // NOP, wraps to 0
      add(32'h0000_0000, 32'h0200_0063, 32'h0000_0000, 1, 0); // BEQ  x0,x0,+32
      add(32'h0000_0020, 32'hFE10_8CE3, 32'h0000_0000, 1, 0); // BEQ  x1,x1,-8
      add(32'h0000_0018, 32'h0020_C3B3, 32'hFFFF_FFF8, 0, 0); // XOR  x7,x1,x2
      add(32'h0000_001C, 32'h0011_4463, 32'hFFFF_FFF8, 1, 0); // BLT  x2,x1,+8
      add(32'h0000_0024, 32'h0011_6463, 32'hFFFF_FFF8, 0, 0); // BLTU x2,x1,+8
      add(32'h0000_0028, 32'h0030_9413, 32'h0000_0028, 0, 0); // SLLI x8,x1,3
      add(32'h0000_002C, 32'h0300_E493, 32'h0000_0035, 0, 0); // ORI  x9,x1,0x30
      add(32'h0000_0030, 32'h4020_C3B3, 32'h0000_0000, 0, 1); // XOR w/ funct7=0x20
      add(32'h0000_0034, 32'h0010_D463, 32'h0000_0000, 1, 0); // BGE  x1,x1,+8

      // reset with instr_valid held high and the first instruction presented
      bus.instr_valid = 1'b1;
      bus.instr       = 32'h0050_0093;                        // ADDI x1,x0,5
      bus.dbg_raddr   = 5'd0;
      rst_n           = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
      check("rst_pc", bus.pc, RPC);
      check("rst_retire_valid", {31'd0, bus.retire_valid}, 32'd0);
      check("rst_retire_pc", bus.retire_pc, 32'd0);
      check("rst_aluresult", bus.aluresult, 32'd0);
      check("rst_branch_taken", {31'd0, bus.branch_taken}, 32'd0);
      check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
      for (int i = 0; i < 16; i++) dbg_check(i, 32'd0);

      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.push_back(exp_t'{RPC, 32'd5, 1'b0, 1'b0});
      @(negedge clk);
      check("ready_first_cycle", {31'd0, bus.instr_ready}, 32'd0);
      @(negedge clk);
      check("ready_second_cycle", {31'd0, bus.instr_ready}, 32'd1);
      check("first_pc", bus.pc, RPC);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;

      for (int k = 0; k < prog.size(); k++) begin
         toggle_en = (k >= 3);
         issue(prog[k].pc, prog[k].word, prog[k].res, prog[k].taken, prog[k].ill, 1'b1);
      end
      drain();
      check("final_pc", bus.pc, 32'h0000_003C);

      dbg_check(0, 32'h0000_0000);
      dbg_check(1, 32'h0000_0005);
      dbg_check(2, 32'hFFFF_FFFD);
      dbg_check(3, 32'h0000_0002);
      dbg_check(4, 32'hFFFF_FFF8);
      dbg_check(5, 32'hFFFF_FFFE);
      dbg_check(6, 32'hABCD_E000);
      dbg_check(7, 32'hFFFF_FFF8);
      dbg_check(8, 32'h0000_0028);
      dbg_check(9, 32'h0000_0035);
      dbg_check(10, 32'h0000_0000);
      dbg_check(20, 32'h0000_0000);

      // reset arriving while ADDI x10,x0,9 is in EXECUTE
      issue(32'h0000_003C, 32'h0090_0513, 32'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_pc", bus.pc, RPC);
      check("abort_ready", {31'd0, bus.instr_ready}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("abort_retire_valid", {31'd0, bus.retire_valid}, 32'd0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      dbg_check(10, 32'h0000_0000);
      dbg_check(1, 32'h0000_0000);

      issue(RPC, 32'h0010_0593, 32'h0000_0001, 1'b0, 1'b0, 1'b1); // ADDI x11,x0,1
      drain();
      dbg_check(11, 32'h0000_0001);
      check("post_reset_pc", bus.pc, 32'h0000_0104);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
